// File: rtl/mapu_op_arbiter_if.sv
// Bundle carrying the requester fabric, MAPU core and completion signals of mapu_op_arbiter.
// slave = the arbiter itself; master = the environment (requesters + core) around it.
interface mapu_op_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int OP_W    = 32
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ*OP_W-1:0] req_op;
    logic [NUM_REQ-1:0]      req_ready;
    logic                    apu_valid;
    logic [OP_W-1:0]         apu_op;
    logic                    apu_ready;
    logic                    apu_done;
    logic                    apu_error;
    logic [NUM_REQ-1:0]      rsp_valid;
    logic                    rsp_error;
    logic                    busy;
    logic [ID_W-1:0]         grant_id;

    modport master (
        output req_valid, req_op, apu_ready, apu_done, apu_error,
        input  req_ready, apu_valid, apu_op, rsp_valid, rsp_error, busy, grant_id
    );

    modport slave (
        input  req_valid, req_op, apu_ready, apu_done, apu_error,
        output req_ready, apu_valid, apu_op, rsp_valid, rsp_error, busy, grant_id
    );
endinterface

// File: rtl/mapu_op_arbiter.sv
// Round-robin arbiter sharing one MAPU datapath; one op in flight (IDLE->ISSUE->WAIT->RESP).
// Optional WAIT watchdog is compiled in when MAPU_ARB_TIMEOUT_EN is defined.
module mapu_op_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int OP_W      = 32,
    parameter int TIMEOUT_W = 12
) (
    input  logic             clk,
    input  logic             reset_n,
    mapu_op_arbiter_if.slave bus
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state, state_nxt;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    grant;
    logic [ID_W-1:0]    grant_inc;
    logic               grant_any;
    logic               timeout;
    logic               apu_valid_q;
    logic [OP_W-1:0]    apu_op_q;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic               rsp_error_q;
    logic [ID_W-1:0]    grant_id_q;

    // First requesting index at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_any = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!grant_any && bus.req_valid[idx]) begin
                grant_any = 1'b1;
                grant     = ID_W'(idx);
            end
        end
    end

    assign grant_inc = (int'(grant) == NUM_REQ - 1) ? '0 : grant + 1'b1;

    always_comb begin
        bus.req_ready = '0;
        if (state == IDLE && grant_any)
            bus.req_ready[grant] = 1'b1;
    end

`ifdef MAPU_ARB_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] wd_cnt;

    // Held at zero outside WAIT, so every WAIT visit starts counting from zero.
    always_ff @(posedge clk) begin
        if (!reset_n)
            wd_cnt <= '0;
        else if (state != WAIT)
            wd_cnt <= '0;
        else
            wd_cnt <= wd_cnt + 1'b1;
    end

    assign timeout = (state == WAIT) && !bus.apu_done && (wd_cnt == '1);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (grant_any)                       state_nxt = ISSUE;
            ISSUE:   if (apu_valid_q && bus.apu_ready)    state_nxt = WAIT;
            WAIT:    if (bus.apu_done || timeout)         state_nxt = RESP;
            RESP:                                         state_nxt = IDLE;
            default:                                      state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_ptr      <= '0;
            grant_id_q  <= '0;
            apu_valid_q <= 1'b0;
            apu_op_q    <= '0;
            rsp_valid_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (grant_any) begin
                    apu_op_q    <= bus.req_op[int'(grant)*OP_W +: OP_W];
                    grant_id_q  <= grant;
                    rr_ptr      <= grant_inc;
                    apu_valid_q <= 1'b1;
                end
                ISSUE: if (apu_valid_q && bus.apu_ready)
                    apu_valid_q <= 1'b0;
                // A real completion wins over a terminal count in the same cycle.
                WAIT: if (bus.apu_done) begin
                    rsp_valid_q <= {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id_q;
                    rsp_error_q <= bus.apu_error;
                end else if (timeout) begin
                    rsp_valid_q <= {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id_q;
                    rsp_error_q <= 1'b1;
                end
                RESP: begin
                    rsp_valid_q <= '0;
                    rsp_error_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.apu_valid = apu_valid_q;
    assign bus.apu_op    = apu_op_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_error = rsp_error_q;
    assign bus.grant_id  = grant_id_q;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_mapu_op_arbiter.sv
module tb_mapu_op_arbiter;
    localparam int N  = 4;
    localparam int OW = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mapu_op_arbiter_if #(.NUM_REQ(N), .OP_W(OW)) bus ();

    mapu_op_arbiter #(.NUM_REQ(N), .OP_W(OW), .TIMEOUT_W(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_run = 0;
    int n_fail = 0;
    logic [N-1:0]  pending;
    logic [OW-1:0] ops [N];
    int            rr_m;
    int            g;

    task automatic chk(input string tag, input logic ok);
        n_run++;
        if (ok !== 1'b1) begin
            n_fail++;
            $error("FAIL %s", tag);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req();
        bus.req_valid = pending;
        for (int i = 0; i < N; i++) bus.req_op[i*OW +: OW] = ops[i];
    endtask

    function automatic int model_grant(input logic [N-1:0] m, input int rr);
        int best, bestd, d;
        best = -1;
        bestd = N;
        for (int i = 0; i < N; i++) begin
            d = (i - rr + N) % N;
            if (m[i] && d < bestd) begin
                best = i;
                bestd = d;
            end
        end
        return best;
    endfunction

    task automatic do_op(input int rd, input int dd, input logic err, output int gr);
        logic [OW-1:0] exp_op;
        gr = model_grant(pending, rr_m);
        exp_op = ops[gr];
        drive_req();
        #1;
        chk("req_ready_idle", bus.req_ready === 4'(1 << gr));
        cyc();
        pending[gr] = 1'b0;
        drive_req();
        bus.apu_ready = (rd == 0);
        #1;
        chk("apu_valid_issue", bus.apu_valid === 1'b1);
        chk("apu_op", bus.apu_op === exp_op);
        chk("grant_id", bus.grant_id === 2'(gr));
        chk("busy_issue", bus.busy === 1'b1);
        chk("req_ready_busy", bus.req_ready === 4'b0);
        rr_m = (gr + 1) % N;
        for (int k = 0; k < rd; k++) begin
            bus.apu_done = 1'($urandom_range(0, 1));
            cyc();
            if (k == rd - 1) begin
                bus.apu_done  = 1'b0;
                bus.apu_ready = 1'b1;
            end
            #1;
            chk("apu_valid_held", bus.apu_valid === 1'b1);
            chk("apu_op_stable", bus.apu_op === exp_op);
            chk("req_ready_stall", bus.req_ready === 4'b0);
            chk("rsp_stall", bus.rsp_valid === 4'b0);
        end
        cyc();
        bus.apu_ready = 1'b0;
        #1;
        chk("apu_valid_drop", bus.apu_valid === 1'b0);
        for (int k = 0; k < dd; k++) begin
            chk("rsp_wait", bus.rsp_valid === 4'b0);
            chk("busy_wait", bus.busy === 1'b1);
            cyc();
            #1;
        end
        bus.apu_done  = 1'b1;
        bus.apu_error = err;
        cyc();
        bus.apu_done  = 1'b0;
        bus.apu_error = 1'($urandom_range(0, 1));
        #1;
        chk("rsp_valid", bus.rsp_valid === 4'(1 << gr));
        chk("rsp_error", bus.rsp_error === err);
        chk("busy_resp", bus.busy === 1'b1);
        cyc();
        #1;
        chk("rsp_clear", bus.rsp_valid === 4'b0);
        chk("busy_idle", bus.busy === 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.apu_ready = 1'b0;
        bus.apu_done  = 1'b0;
        bus.apu_error = 1'b0;
        pending = '0;
        for (int i = 0; i < N; i++) ops[i] = '0;
        rr_m = 0;

        cyc();
        cyc();
        chk("rst_busy", bus.busy === 1'b0);
        chk("rst_apu_valid", bus.apu_valid === 1'b0);
        chk("rst_apu_op", bus.apu_op === 32'h0);
        chk("rst_rsp_valid", bus.rsp_valid === 4'b0);
        chk("rst_rsp_error", bus.rsp_error === 1'b0);
        chk("rst_grant_id", bus.grant_id === 2'd0);
        chk("rst_req_ready", bus.req_ready === 4'b0);
        reset_n = 1'b1;
        cyc();

        for (int k = 0; k < 5; k++) begin
            pending = '1;
            for (int i = 0; i < N; i++) ops[i] = $urandom;
            do_op(0, 0, 1'b0, g);
            chk("fair_order", bus.grant_id === 2'(k % N));
        end

        pending = 4'b0010;
        ops[1] = 32'hA5A5_0001;
        do_op(0, 3, 1'b0, g);

        pending = 4'b1000;
        ops[3] = 32'hDEAD_BEEF;
        do_op(1, 1, 1'b1, g);

        pending = 4'b0100;
        ops[2] = 32'h1234_5678;
        do_op(5, 2, 1'b0, g);

        pending = 4'b0100;
        ops[2] = 32'hCAFE_0002;
        drive_req();
        cyc();
        pending = '0;
        drive_req();
        bus.apu_ready = 1'b1;
        cyc();
        bus.apu_ready = 1'b0;
        cyc();
        cyc();
        reset_n = 1'b0;
        bus.apu_done = 1'b1;
        cyc();
        reset_n = 1'b1;
        bus.apu_done = 1'b0;
        #1;
        chk("midrst_busy", bus.busy === 1'b0);
        chk("midrst_rsp", bus.rsp_valid === 4'b0);
        chk("midrst_grant_id", bus.grant_id === 2'd0);
        chk("midrst_apu_valid", bus.apu_valid === 1'b0);
        rr_m = 0;
        cyc();
        #1;
        chk("midrst_no_rsp", bus.rsp_valid === 4'b0);
        pending = '1;
        for (int i = 0; i < N; i++) ops[i] = $urandom;
        do_op(0, 0, 1'b0, g);
        chk("midrst_regrant", bus.grant_id === 2'd0);
        pending = '0;
        drive_req();

`ifdef MAPU_ARB_TIMEOUT_EN
        pending = 4'b1000;
        ops[3] = 32'h0BAD_F00D;
        g = model_grant(pending, rr_m);
        drive_req();
        cyc();
        pending = '0;
        drive_req();
        bus.apu_ready = 1'b1;
        cyc();
        bus.apu_ready = 1'b0;
        rr_m = (g + 1) % N;
        cnt = 0;
        while (bus.rsp_valid == 4'b0 && cnt < 40) begin
            cyc();
            cnt++;
        end
        chk("timeout_rsp", bus.rsp_valid === 4'(1 << g));
        chk("timeout_err", bus.rsp_error === 1'b1);
        cyc();
        #1;
        chk("timeout_idle", bus.busy === 1'b0);
`else
        cnt = 0;
        pending = 4'b1000;
        ops[3] = 32'h0BAD_F00D;
        do_op(0, 100, 1'b0, g);
`endif

        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < N; i++)
                if (!pending[i] && $urandom_range(0, 1) == 1) begin
                    pending[i] = 1'b1;
                    ops[i] = $urandom;
                end
            if (pending != '0 && $urandom_range(0, 3) == 0)
                pending[$urandom_range(0, N-1)] = 1'b0;
            if (pending == '0) begin
                drive_req();
                #1;
                chk("idle_req_ready", bus.req_ready === 4'b0);
                cyc();
                #1;
                chk("idle_busy", bus.busy === 1'b0);
            end else begin
                do_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), g);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
